xbus_master_bridge: RTL and testbench

//  Converts the core's single-outstanding memory request into an xbus transaction.

---
 rtl/xbus_pkg.sv | 25 ++
 rtl/xbus_resp_mux.sv | 26 ++
 rtl/xbus_master_bridge.sv | 113 +++++++++++
 tb/tb_xbus_master_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared xbus definitions: default sizing, bridge state encoding and the
// address map that the external decoder implements.
package xbus_pkg;

    localparam int XBUS_NSLAVES = 4;
    localparam int XBUS_DW      = 32;
    localparam int XBUS_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    // Slave windows: base and match mask per chip select
    localparam logic [31:0] S0_BASE = 32'h0000_1000;
    localparam logic [31:0] S0_MASK = 32'hFFFF_F000;
    localparam logic [31:0] S1_BASE = 32'h8000_0000;
    localparam logic [31:0] S1_MASK = 32'hFFFF_0000;
    localparam logic [31:0] S2_BASE = 32'h0000_3000;
    localparam logic [31:0] S2_MASK = 32'hFFFF_F000;
    localparam logic [31:0] S3_BASE = 32'h4000_0000;
    localparam logic [31:0] S3_MASK = 32'hFFFF_0000;

endpackage

// File: rtl/xbus_resp_mux.sv
// One-hot AND-OR return path from the xbus slaves, plus a flag that
// fires when the decoder selects more than one slave.
module xbus_resp_mux #(
    parameter int NSLAVES = 4,
    parameter int DW      = 32
) (
    input  logic [NSLAVES-1:0]    cs,
    input  logic [NSLAVES*DW-1:0] rdata,
    input  logic [NSLAVES-1:0]    ack,
    output logic [DW-1:0]         sel_rdata,
    output logic                  sel_ack,
    output logic                  multi
);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (cs[i]) sel_rdata = sel_rdata | rdata[i*DW +: DW];
        end
    end

    assign sel_ack = |(ack & cs);
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi   = |(cs & (cs - NSLAVES'(1)));

endmodule

// File: rtl/xbus_master_bridge.sv
// Turns a single outstanding core request into one xbus strobe and
// returns the selected slave's response, or an error on bad decode/timeout.
module xbus_master_bridge
    import xbus_pkg::*;
#(
    parameter int NSLAVES = XBUS_NSLAVES,
    parameter int TIMEOUT = XBUS_TIMEOUT,
    parameter int DW      = XBUS_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [DW-1:0]         cpu_wdata,
    input  logic [DW/8-1:0]       cpu_be,
    output logic                  cpu_ready,
    output logic [DW-1:0]         cpu_rdata,
    output logic                  cpu_err,
    output logic                  xbus_as,
    output logic [31:0]           xbus_addr,
    output logic                  xbus_we,
    output logic [DW-1:0]         xbus_wdata,
    output logic [DW/8-1:0]       xbus_be,
    input  logic [NSLAVES-1:0]    xbus_cs,
    input  logic [NSLAVES*DW-1:0] xbus_rdata,
    input  logic [NSLAVES-1:0]    xbus_ack
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    logic [DW-1:0] sel_rdata;
    logic          sel_ack;
    logic          multi;
    logic          no_cs;
    logic          at_limit;
    logic          bus_done;
    logic          bus_err;

    xbus_resp_mux #(
        .NSLAVES (NSLAVES),
        .DW      (DW)
    ) u_mux (
        .cs        (xbus_cs),
        .rdata     (xbus_rdata),
        .ack       (xbus_ack),
        .sel_rdata (sel_rdata),
        .sel_ack   (sel_ack),
        .multi     (multi)
    );

    // Decode faults outrank ack; ack outranks the timeout
    always_comb begin
        no_cs    = (xbus_cs == '0);
        at_limit = (cnt == CNT_LAST);
        bus_err  = no_cs | multi | (~sel_ack & at_limit);
        bus_done = no_cs | multi | sel_ack | at_limit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            xbus_as    <= 1'b0;
            xbus_addr  <= '0;
            xbus_we    <= 1'b0;
            xbus_wdata <= '0;
            xbus_be    <= '0;
            cpu_ready  <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                    if (cpu_req) begin
                        xbus_as    <= 1'b1;
                        xbus_addr  <= cpu_addr;
                        xbus_we    <= cpu_we;
                        xbus_wdata <= cpu_wdata;
                        xbus_be    <= cpu_be;
                        cnt        <= '0;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (!at_limit) cnt <= cnt + CW'(1);
                    if (bus_done) begin
                        xbus_as   <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= bus_err;
                        cpu_rdata <= (xbus_we || bus_err) ? '0 : sel_rdata;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_master_bridge.sv
// Bench for xbus_master_bridge: decoder and slaves modelled here, table
// vectors, hand sequences and randomized traffic against a latency model.
module tb_xbus_master_bridge;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          dly;
        logic [3:0]  fcs;
        logic [3:0]  spur;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cpu_req;
    logic           cpu_we;
    logic [31:0]    cpu_addr;
    logic [DW-1:0]  cpu_wdata;
    logic [3:0]     cpu_be;
    logic           cpu_ready;
    logic [DW-1:0]  cpu_rdata;
    logic           cpu_err;
    logic           xbus_as;
    logic [31:0]    xbus_addr;
    logic           xbus_we;
    logic [DW-1:0]  xbus_wdata;
    logic [3:0]     xbus_be;
    logic [NS-1:0]  xbus_cs;
    logic [NS*DW-1:0] xbus_rdata;
    logic [NS-1:0]  xbus_ack;

    logic [31:0] sdata [NS];
    int          dly   [NS];
    logic [3:0]  fcs;
    logic [3:0]  spur;
    int          bcnt;

    int checks   = 0;
    int failures = 0;

    xbus_master_bridge #(
        .NSLAVES (NS),
        .TIMEOUT (TMO),
        .DW      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .xbus_as    (xbus_as),
        .xbus_addr  (xbus_addr),
        .xbus_we    (xbus_we),
        .xbus_wdata (xbus_wdata),
        .xbus_be    (xbus_be),
        .xbus_cs    (xbus_cs),
        .xbus_rdata (xbus_rdata),
        .xbus_ack   (xbus_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dec(input logic [31:0] a);
        if (a[31:12] == 20'h00001) return 4'b0001;
        if (a[31:16] == 16'h8000)  return 4'b0010;
        if (a[31:12] == 20'h00003) return 4'b0100;
        if (a[31:16] == 16'h4000)  return 4'b1000;
        return 4'b0000;
    endfunction

    // Strobe-length counter seen by the slaves: 0 in the first strobe cycle
    always @(posedge clk) bcnt <= xbus_as ? bcnt + 1 : 0;

    always_comb begin
        xbus_cs = '0;
        if (xbus_as) xbus_cs = (fcs != 0) ? fcs : dec(xbus_addr);
        for (int i = 0; i < NS; i++)
            xbus_ack[i] = spur[i] | (xbus_as & xbus_cs[i] & (bcnt == dly[i]));
        xbus_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                input int d, input logic [3:0] f,
                                input logic [3:0] s, input logic e,
                                input logic [31:0] rd, input int lat);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.dly = d;
        v.fcs = f; v.spur = s; v.exp_err = e; v.exp_rdata = rd;
        v.exp_lat = lat;
        return v;
    endfunction

    // Called at #1 after a rising edge with the bridge idle
    task automatic run(input vec_t v, input string tag);
        int lat, asc, bad;
        for (int i = 0; i < NS; i++) dly[i] = v.dly;
        fcs = v.fcs; spur = v.spur;
        cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        cpu_be = v.be; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 1; asc = 0; bad = 0;
        while (!cpu_ready && lat < 60) begin
            if (xbus_as) begin
                asc++;
                if (xbus_addr !== v.addr || xbus_wdata !== v.wdata ||
                    xbus_be !== v.be || xbus_we !== v.we) bad++;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " err"}, {31'd0, cpu_err}, {31'd0, v.exp_err});
        chk({tag, " rdata"}, cpu_rdata, v.exp_rdata);
        chk({tag, " as_cycles"}, asc, v.exp_lat - 1);
        chk({tag, " xbus_stable"}, bad, 0);
        @(posedge clk); #1;
        chk({tag, " ready_pulse"}, {31'd0, cpu_ready}, 32'd0);
        fcs = '0; spur = '0;
    endtask

    vec_t vt [8];
    vec_t rv;

    initial begin
        int k, d, rdy_seen;
        logic [3:0] cs_exp;
        logic [31:0] base [NS];
        base[0] = 32'h0000_1000; base[1] = 32'h8000_0000;
        base[2] = 32'h0000_3000; base[3] = 32'h4000_0000;

        sdata[0] = 32'hDEADBEEF; sdata[1] = 32'hCAFEF00D;
        sdata[2] = 32'h0BADC0DE; sdata[3] = 32'h13579BDF;
        for (int i = 0; i < NS; i++) dly[i] = 0;
        fcs = '0; spur = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst as", {31'd0, xbus_as}, 32'd0);
        chk("rst ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst err", {31'd0, cpu_err}, 32'd0);
        chk("rst rdata", cpu_rdata, 32'd0);
        chk("rst addr", xbus_addr, 32'd0);
        chk("rst wdata", xbus_wdata, 32'd0);
        chk("rst be_we", {27'd0, xbus_be, xbus_we}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vt[0] = mk(0, 32'h0000_1004, 32'h0, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 2);
        vt[1] = mk(1, 32'h8000_0010, 32'h12345678, 4'b0011, 4, 0, 0, 0, 0, 6);
        vt[2] = mk(0, 32'h0000_2000, 32'h0, 4'hF, 0, 0, 0, 1, 0, 2);
        vt[3] = mk(0, 32'h0000_1000, 32'h0, 4'hF, 99, 0, 4'b0100, 1, 0, TMO + 1);
        vt[4] = mk(0, 32'h0000_1000, 32'h0, 4'hF, 0, 4'b0011, 0, 1, 0, 2);
        vt[5] = mk(0, 32'h0000_3008, 32'h0, 4'hF, TMO - 1, 0, 0, 0, 32'h0BADC0DE, TMO + 1);
        vt[6] = mk(1, 32'h4000_0020, 32'hA5A5_5A5A, 4'b1100, 1, 0, 0, 0, 0, 3);
        vt[7] = mk(0, 32'h8000_0100, 32'h0, 4'hF, 2, 0, 4'b1000, 0, 32'hCAFEF00D, 4);
        for (int i = 0; i < 8; i++) run(vt[i], $sformatf("vec%0d", i));

        // Reset during the strobe: as drops at once, no response follows
        for (int i = 0; i < NS; i++) dly[i] = 50;
        cpu_we = 0; cpu_addr = 32'h0000_1000; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst as_before", {31'd0, xbus_as}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst as_drop", {31'd0, xbus_as}, 32'd0);
        rdy_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            rdy_seen += int'(cpu_ready);
        end
        chk("midrst no_ready", rdy_seen, 0);
        chk("midrst addr", xbus_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(mk(0, 32'h0000_1040, 32'h0, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 2), "postrst");

        // Random traffic against a latency/response model
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 4);
            d = $urandom_range(0, 19);
            for (int i = 0; i < NS; i++) sdata[i] = $urandom;
            rv.we    = 1'($urandom_range(0, 1));
            rv.wdata = $urandom;
            rv.be    = 4'($urandom);
            rv.dly   = d;
            rv.fcs   = '0;
            if (k < 4) begin
                rv.addr = base[k] | {20'd0, 10'($urandom), 2'b00};
                cs_exp  = 4'b0001 << k;
            end else begin
                rv.addr = 32'h0000_2000 | {20'd0, 10'($urandom), 2'b00};
                cs_exp  = 4'b0000;
            end
            if ($urandom_range(0, 7) == 0) begin
                rv.fcs = 4'b0011 << $urandom_range(0, 2);
                cs_exp = rv.fcs;
            end
            rv.spur = 4'($urandom) & ~cs_exp;
            if ($countones(cs_exp) != 1) begin
                rv.exp_err = 1; rv.exp_lat = 2; rv.exp_rdata = 0;
            end else if (d < TMO) begin
                rv.exp_err   = 0;
                rv.exp_lat   = d + 2;
                rv.exp_rdata = rv.we ? 32'd0 : sdata[k];
            end else begin
                rv.exp_err = 1; rv.exp_lat = TMO + 1; rv.exp_rdata = 0;
            end
            run(rv, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
